tsoip_rx_depacketizer: RTL and testbench
========================================

Name: tsoip_rx_depacketizer

Overview:
Receive-side counterpart of the TS-over-IP transmit path. Takes 4-bit MII receive nibbles from the Ethernet PHY, assembles bytes, parses the Ethernet/IPv4/UDP headers and filters on the local MAC, IP and port. From accepted frames it extracts the transport-stream payload as a byte stream with valid/sync strobes, for the ASI/TS output side.

Parameters:
TS_LEN, 188, TS packet length in bytes (204 supported)
MAX_PKTS, 7, maximum TS packets per UDP datagram

Ports:
i_PhyRxClk  input  1  PHY receive clock, 25 MHz; the only clock
i_nRst  input  1  asynchronous active-low reset
i_PhyRxDv  input  1  MII receive data valid
i_PhyRxEr  input  1  MII receive error
i_PhyRxData  input  4  MII receive nibble, low nibble of each byte first
i_MacLocal  input  48  accepted destination MAC
i_IpLocal  input  32  accepted destination IP
i_PortLocal  input  16  accepted UDP destination port
o_ts_Data  output  8  extracted TS byte
o_ts_Valid  output  1  o_ts_Data valid, one-cycle strobe
o_ts_Sync  output  1  high with the first byte of each TS packet
o_ts_Err  output  1  one-cycle pulse: current TS packet truncated or bad sync byte
o_FramesOk  output  16  accepted-frame counter, saturating
o_FramesDrop  output  16  rejected/aborted-frame counter, saturating

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, nibble phase 0.
- Byte assembly: the first nibble with DV high in a byte is bits[3:0], the second is bits[7:4]. A byte completes every 2 clocks. Byte index counts from the first byte after the SFD.
- FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- IDLE: on DV=1, go to PREAMBLE.
- PREAMBLE: on an assembled byte equal to 0xD5 (SFD), go to HEADER and clear the byte index. If DV falls first, return to IDLE with no counter change.
- HEADER: 42 bytes (Eth 14, IP 20, UDP 8). Each field is compared as its last byte arrives:
  - bytes 0-5 must equal i_MacLocal (MSB first)
  - bytes 12-13 must be 0x0800
  - byte 14 must be 0x45
  - byte 23 must be 0x11
  - bytes 30-33 must equal i_IpLocal
  - bytes 36-37 must equal i_PortLocal
  - bytes 38-39 hold UDP length L; the payload is P = L-8.
- Length check: P must be N*TS_LEN with 1 ≤ N ≤ MAX_PKTS. The check uses a compare against a constant table of multiples, not a divider.
- Any HEADER mismatch -> DROP. No payload bytes are emitted for a dropped frame.
- PAYLOAD:
  - every assembled byte drives o_ts_Data with o_ts_Valid=1 for one cycle, 1 cycle after the second nibble
  - o_ts_Sync=1 on byte offsets that are multiples of TS_LEN
  - if a sync-position byte is not 0x47, pulse o_ts_Err with that byte; forwarding continues
  - after P bytes, o_FramesOk increments, then go to DROP to discard trailing bytes and the FCS (FCS is not checked).
- DROP: wait for DV=0, then go to IDLE. o_FramesDrop increments once on entry from HEADER or an abort. It does not increment on normal completion.
- Abort:
  - i_PhyRxEr=1 or DV=0 during HEADER or PAYLOAD aborts the frame.
  - In PAYLOAD, if the current TS packet is partial, pulse o_ts_Err on the abort cycle. Bytes already emitted are not retracted.
  - Then o_FramesDrop increments and go to DROP, or IDLE if DV=0.
- DV falling with an odd nibble count: the half byte is discarded.
- Counters: 16-bit, saturate at 0xFFFF, no wrap.
- Simultaneous events: a final payload byte and RxEr in the same cycle are treated as an abort. The byte is not emitted and o_FramesOk does not increment.
- Filter inputs are sampled continuously. Software changes them only while idle, so no stability requirement mid-frame is imposed.
- Back-to-back frames with the minimum 12-byte IFG (24 cycles DV low) must be fully received.

Test Plan:
1. Valid frame, MAC 74:86:7a:fb:78:c7, IP 10.0.27.31, port 3000, UDP L=1324 (7×188) -> 1316 o_ts_Valid strobes; 7 o_ts_Sync pulses at 376-clock spacing, each on byte 0x47; o_FramesOk=1, o_FramesDrop=0.
2. Same frame with destination MAC aa:bb:cc:dd:ee:ff -> zero o_ts_Valid; o_FramesDrop=1.
3. Frame with protocol 0x06, then a frame with UDP L=200 (192 not a multiple of 188) -> no output for either; o_FramesDrop=2.
4. Valid 7-packet frame with i_PhyRxEr asserted at payload byte 400 -> 400 bytes emitted; o_ts_Err pulse (packet 3 partial); o_FramesDrop=1, o_FramesOk=0.
5. Third TS packet starts with 0x48 -> o_ts_Err coincident with the third o_ts_Sync; all 1316 bytes still emitted; o_FramesOk=1.
6. i_nRst pulsed low mid-payload -> outputs and counters 0 immediately. The next valid frame is received normally with o_FramesOk=1. With TS_LEN=204 and L=1436, seven 204-byte packets are emitted.

Source files
------------

// File: rtl/tsoip_rx_depacketizer.sv
// MII receive path for TS-over-IP: nibble-to-byte assembly, Eth/IPv4/UDP header filtering
// and extraction of the transport-stream payload as a strobed byte stream.
module tsoip_rx_depacketizer #(
  parameter int unsigned TS_LEN   = 188,
  parameter int unsigned MAX_PKTS = 7
) (
  input  logic        i_PhyRxClk,
  input  logic        i_nRst,
  input  logic        i_PhyRxDv,
  input  logic        i_PhyRxEr,
  input  logic [3:0]  i_PhyRxData,
  input  logic [47:0] i_MacLocal,
  input  logic [31:0] i_IpLocal,
  input  logic [15:0] i_PortLocal,
  output logic [7:0]  o_ts_Data,
  output logic        o_ts_Valid,
  output logic        o_ts_Sync,
  output logic        o_ts_Err,
  output logic [15:0] o_FramesOk,
  output logic [15:0] o_FramesDrop
);

  localparam int unsigned HDR_LEN = 42;
  localparam int unsigned PKT_W   = $clog2(TS_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t r_State, w_NextState;

  logic             r_Phase;
  logic [3:0]       r_LoNib;
  logic [39:0]      r_Shift;
  logic [5:0]       r_HdrIdx;
  logic [15:0]      r_PayLen;
  logic [15:0]      r_PayOff;
  logic [PKT_W-1:0] r_PktOff;

  logic        w_ByteDone;
  logic [7:0]  w_Byte;
  logic        w_Abort;
  logic [15:0] w_Len;
  logic [15:0] w_Pay;
  logic        w_LenOk;
  logic        w_HdrBad;
  logic        w_HdrLast;
  logic        w_PayLast;
  logic        w_Emit, w_Sync, w_Err, w_OkInc, w_DropInc;

  assign w_ByteDone = i_PhyRxDv & r_Phase;
  assign w_Byte     = {i_PhyRxData, r_LoNib};
  assign w_Abort    = ~i_PhyRxDv | i_PhyRxEr;
  assign w_Len      = {r_Shift[7:0], w_Byte};
  assign w_Pay      = w_Len - 16'd8;
  assign w_HdrLast  = (r_HdrIdx == 6'(HDR_LEN - 1));
  assign w_PayLast  = (r_PayOff == r_PayLen - 16'd1);

  // Payload must be a whole number of TS packets; compare against constant multiples
  always_comb begin
    w_LenOk = 1'b0;
    for (int unsigned k = 1; k <= MAX_PKTS; k++) begin
      if (w_Pay == 16'(k * TS_LEN)) w_LenOk = 1'b1;
    end
  end

  // Each field is judged when its last byte arrives; earlier bytes sit in r_Shift
  always_comb begin
    w_HdrBad = 1'b0;
    case (r_HdrIdx)
      6'd5:    w_HdrBad = ({r_Shift, w_Byte} != i_MacLocal);
      6'd13:   w_HdrBad = ({r_Shift[7:0], w_Byte} != 16'h0800);
      6'd14:   w_HdrBad = (w_Byte != 8'h45);
      6'd23:   w_HdrBad = (w_Byte != 8'h11);
      6'd33:   w_HdrBad = ({r_Shift[23:0], w_Byte} != i_IpLocal);
      6'd37:   w_HdrBad = ({r_Shift[7:0], w_Byte} != i_PortLocal);
      6'd39:   w_HdrBad = ~w_LenOk;
      default: w_HdrBad = 1'b0;
    endcase
  end

  always_ff @(posedge i_PhyRxClk or negedge i_nRst) begin
    if (!i_nRst) r_State <= S_IDLE;
    else         r_State <= w_NextState;
  end

  always_comb begin
    w_NextState = r_State;
    case (r_State)
      S_IDLE:     if (i_PhyRxDv) w_NextState = S_PREAMBLE;
      S_PREAMBLE: begin
        if (!i_PhyRxDv)                          w_NextState = S_IDLE;
        else if (w_ByteDone && w_Byte == 8'hD5) w_NextState = S_HEADER;
      end
      S_HEADER: begin
        if (w_Abort)         w_NextState = i_PhyRxDv ? S_DROP : S_IDLE;
        else if (w_ByteDone) begin
          if (w_HdrBad)       w_NextState = S_DROP;
          else if (w_HdrLast) w_NextState = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_Abort)                       w_NextState = i_PhyRxDv ? S_DROP : S_IDLE;
        else if (w_ByteDone && w_PayLast) w_NextState = S_DROP;
      end
      S_DROP:     if (!i_PhyRxDv) w_NextState = S_IDLE;
      default:    w_NextState = S_IDLE;
    endcase
  end

  // Abort wins over a byte completing in the same cycle
  always_comb begin
    w_Emit    = 1'b0;
    w_Sync    = 1'b0;
    w_Err     = 1'b0;
    w_OkInc   = 1'b0;
    w_DropInc = 1'b0;
    case (r_State)
      S_HEADER: w_DropInc = w_Abort | (w_ByteDone & w_HdrBad);
      S_PAYLOAD: begin
        if (w_Abort) begin
          w_DropInc = 1'b1;
          w_Err     = (r_PktOff != '0);
        end else if (w_ByteDone) begin
          w_Emit  = 1'b1;
          w_Sync  = (r_PktOff == '0);
          w_Err   = (r_PktOff == '0) && (w_Byte != 8'h47);
          w_OkInc = w_PayLast;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_PhyRxClk or negedge i_nRst) begin
    if (!i_nRst) begin
      r_Phase      <= 1'b0;
      r_LoNib      <= '0;
      r_Shift      <= '0;
      r_HdrIdx     <= '0;
      r_PayLen     <= '0;
      r_PayOff     <= '0;
      r_PktOff     <= '0;
      o_ts_Data    <= '0;
      o_ts_Valid   <= 1'b0;
      o_ts_Sync    <= 1'b0;
      o_ts_Err     <= 1'b0;
      o_FramesOk   <= '0;
      o_FramesDrop <= '0;
    end else begin
      r_Phase <= i_PhyRxDv & ~r_Phase;
      if (i_PhyRxDv && !r_Phase) r_LoNib <= i_PhyRxData;
      if (w_ByteDone) r_Shift <= {r_Shift[31:0], w_Byte};

      if (r_State == S_PREAMBLE)                   r_HdrIdx <= '0;
      else if (r_State == S_HEADER && w_ByteDone) r_HdrIdx <= r_HdrIdx + 6'd1;
      if (r_State == S_HEADER && w_ByteDone && r_HdrIdx == 6'd39) r_PayLen <= w_Pay;

      if (r_State == S_HEADER) begin
        r_PayOff <= '0;
        r_PktOff <= '0;
      end else if (w_Emit) begin
        r_PayOff <= r_PayOff + 16'd1;
        r_PktOff <= (r_PktOff == PKT_W'(TS_LEN - 1)) ? '0 : r_PktOff + PKT_W'(1);
      end

      o_ts_Valid <= w_Emit;
      o_ts_Sync  <= w_Sync;
      o_ts_Err   <= w_Err;
      if (w_Emit) o_ts_Data <= w_Byte;

      if (w_OkInc && o_FramesOk != '1)     o_FramesOk   <= o_FramesOk + 16'd1;
      if (w_DropInc && o_FramesDrop != '1) o_FramesDrop <= o_FramesDrop + 16'd1;
    end
  end

endmodule

// File: tb/tb_tsoip_rx_depacketizer.sv
// Bench for tsoip_rx_depacketizer: builds whole frames, streams them as MII nibbles and
// compares the extracted TS stream and counters with a frame-level reference model.
module tb_tsoip_rx_depacketizer;

  localparam int TS = 188;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic [47:0] mac_local  = 48'h74867afb78c7;
  logic [31:0] ip_local   = 32'h0a001b1f;
  logic [15:0] port_local = 16'd3000;

  logic [7:0]  ts_data, ts2_data;
  logic        ts_valid, ts_sync, ts_err, ts2_valid, ts2_sync, ts2_err;
  logic [15:0] frames_ok, frames_drop, frames2_ok, frames2_drop;

  always #20 clk = ~clk;

  tsoip_rx_depacketizer #(.TS_LEN(188), .MAX_PKTS(7)) u_dut (
    .i_PhyRxClk(clk), .i_nRst(rst_n), .i_PhyRxDv(dv), .i_PhyRxEr(er), .i_PhyRxData(rxd),
    .i_MacLocal(mac_local), .i_IpLocal(ip_local), .i_PortLocal(port_local),
    .o_ts_Data(ts_data), .o_ts_Valid(ts_valid), .o_ts_Sync(ts_sync), .o_ts_Err(ts_err),
    .o_FramesOk(frames_ok), .o_FramesDrop(frames_drop));

  tsoip_rx_depacketizer #(.TS_LEN(204), .MAX_PKTS(7)) u_dut204 (
    .i_PhyRxClk(clk), .i_nRst(rst_n), .i_PhyRxDv(dv), .i_PhyRxEr(er), .i_PhyRxData(rxd),
    .i_MacLocal(mac_local), .i_IpLocal(ip_local), .i_PortLocal(port_local),
    .o_ts_Data(ts2_data), .o_ts_Valid(ts2_valid), .o_ts_Sync(ts2_sync), .o_ts_Err(ts2_err),
    .o_FramesOk(frames2_ok), .o_FramesDrop(frames2_drop));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  logic [7:0] pay[$];
  logic [7:0] mon_data[$];
  logic       mon_sync[$];
  int         mon_sync_t[$];
  int         mon_err, mon_err_sync;
  int         m2_n, m2_sync, m2_bad, m2_err;

  logic [47:0] f_mac;
  logic [15:0] f_etype, f_port, f_len;
  logic [7:0]  f_ver, f_proto;
  logic [31:0] f_ip;

  int exp_n, exp_err, exp_err_sync, exp_ok, exp_drop;

  always @(negedge clk) begin
    cyc++;
    if (ts_valid) begin
      mon_data.push_back(ts_data);
      mon_sync.push_back(ts_sync);
      if (ts_sync) mon_sync_t.push_back(cyc);
    end
    if (ts_err) begin
      mon_err++;
      if (ts_valid && ts_sync) mon_err_sync++;
    end
    if (ts2_valid) begin
      if (ts2_sync != (m2_n % 204 == 0)) m2_bad++;
      if (ts2_sync) m2_sync++;
      m2_n++;
    end
    if (ts2_err) m2_err++;
  end

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not finish (cycles=%0d required<200000)", cyc);
    $fatal(1);
  end

  task automatic clear_mon();
    mon_data.delete();
    mon_sync.delete();
    mon_sync_t.delete();
    mon_err = 0; mon_err_sync = 0;
    m2_n = 0; m2_sync = 0; m2_bad = 0; m2_err = 0;
  endtask

  task automatic set_frame(input logic [47:0] mac, input logic [15:0] etype, input logic [7:0] ver,
                           input logic [7:0] proto, input logic [31:0] ip, input logic [15:0] port,
                           input logic [15:0] len, input int ts, input int bad_pkt);
    logic [15:0] tot;
    f_mac = mac; f_etype = etype; f_ver = ver; f_proto = proto; f_ip = ip; f_port = port; f_len = len;
    pay.delete();
    for (int i = 0; i < int'(len) - 8; i++) begin
      if (i % ts == 0) pay.push_back((i / ts == bad_pkt) ? 8'h48 : 8'h47);
      else             pay.push_back(8'($urandom));
    end
    tx_q.delete();
    repeat (7) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) tx_q.push_back(mac[47-8*i -: 8]);
    repeat (6) tx_q.push_back(8'($urandom));
    tx_q.push_back(etype[15:8]); tx_q.push_back(etype[7:0]);
    tx_q.push_back(ver); tx_q.push_back(8'h00);
    tot = len + 16'd20;
    tx_q.push_back(tot[15:8]); tx_q.push_back(tot[7:0]);
    repeat (4) tx_q.push_back(8'($urandom));
    tx_q.push_back(8'h40); tx_q.push_back(proto);
    repeat (6) tx_q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) tx_q.push_back(ip[31-8*i -: 8]);
    repeat (2) tx_q.push_back(8'($urandom));
    tx_q.push_back(port[15:8]); tx_q.push_back(port[7:0]);
    tx_q.push_back(len[15:8]); tx_q.push_back(len[7:0]);
    repeat (2) tx_q.push_back(8'($urandom));
    foreach (pay[i]) tx_q.push_back(pay[i]);
    repeat (4) tx_q.push_back(8'($urandom));
  endtask

  // Payload byte k sits at tx_q index 50+k (8 preamble/SFD + 42 header)
  task automatic send_frame(input int er_at, input bit er_hi_only, input int stop_at);
    for (int i = 0; i < tx_q.size(); i++) begin
      logic [7:0] b;
      if (stop_at >= 0 && i == 50 + stop_at) return;
      b = tx_q[i];
      for (int nb = 0; nb < 2; nb++) begin
        @(posedge clk); #1;
        dv  = 1'b1;
        rxd = (nb == 1) ? b[7:4] : b[3:0];
        er  = (er_at >= 0 && i == 50 + er_at && (nb == 1 || !er_hi_only));
      end
    end
    @(posedge clk); #1;
    dv = 1'b0; er = 1'b0; rxd = 4'h0;
    repeat (24) @(posedge clk);
  endtask

  task automatic model_frame(input int ts, input int er_at, output int n, output int err,
                             output int err_sync, output int ok_d, output int drop_d);
    int  p;
    bit  acc;
    p   = int'(f_len) - 8;
    acc = (f_mac == mac_local) && (f_etype == 16'h0800) && (f_ver == 8'h45) &&
          (f_proto == 8'h11) && (f_ip == ip_local) && (f_port == port_local) &&
          (p > 0) && (p % ts == 0) && (p / ts <= 7);
    n = 0; err = 0; err_sync = 0; ok_d = 0; drop_d = 1;
    if (acc) begin
      n = (er_at >= 0) ? er_at : p;
      for (int k = 0; k < n; k += ts) if (pay[k] != 8'h47) err_sync++;
      err    = err_sync + ((er_at >= 0 && er_at % ts != 0) ? 1 : 0);
      ok_d   = (er_at < 0) ? 1 : 0;
      drop_d = (er_at >= 0) ? 1 : 0;
    end
  endtask

  task automatic run_frame(input int er_at, input bit er_hi_only);
    int okd, dropd;
    clear_mon();
    send_frame(er_at, er_hi_only, -1);
    model_frame(TS, er_at, exp_n, exp_err, exp_err_sync, okd, dropd);
    exp_ok += okd;
    exp_drop += dropd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ts_data, ts_valid, ts_sync, ts_err} !== 11'd0) begin
      failures++;
      $display("FAIL reset_ts_outputs: got %h/%b/%b/%b required 0", ts_data, ts_valid, ts_sync, ts_err);
    end
    checks++;
    if (frames_ok !== 16'd0 || frames_drop !== 16'd0 || frames2_ok !== 16'd0 || frames2_drop !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: ok=%0d drop=%0d ok204=%0d drop204=%0d required 0",
               frames_ok, frames_drop, frames2_ok, frames2_drop);
    end
    rst_n = 1'b1;
    exp_ok = 0; exp_drop = 0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_valid_frame();
    int bad_data, bad_sync, nsync, bad_gap;
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd1324, TS, -1);
    run_frame(-1, 1'b0);
    bad_data = 0; bad_sync = 0; nsync = 0; bad_gap = 0;
    foreach (mon_data[i]) if (i < exp_n && mon_data[i] !== pay[i]) bad_data++;
    foreach (mon_sync[i]) begin
      if (mon_sync[i]) nsync++;
      if (mon_sync[i] != (i % TS == 0)) bad_sync++;
    end
    for (int i = 1; i < mon_sync_t.size(); i++) if (mon_sync_t[i] - mon_sync_t[i-1] != 2 * TS) bad_gap++;
    checks++;
    if (mon_data.size() != exp_n) begin failures++; $display("FAIL valid_count: got %0d required %0d", mon_data.size(), exp_n); end
    checks++;
    if (bad_data != 0) begin failures++; $display("FAIL valid_data: %0d bytes differ, required 0", bad_data); end
    checks++;
    if (nsync != 7 || bad_sync != 0) begin failures++; $display("FAIL valid_sync: got %0d pulses (%0d misplaced) required 7 (0)", nsync, bad_sync); end
    checks++;
    if (bad_gap != 0) begin failures++; $display("FAIL valid_sync_spacing: %0d gaps not %0d clocks", bad_gap, 2 * TS); end
    checks++;
    if (mon_err != exp_err) begin failures++; $display("FAIL valid_err: got %0d required %0d", mon_err, exp_err); end
    checks++;
    if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
      failures++; $display("FAIL valid_counters: ok=%0d drop=%0d required %0d %0d", frames_ok, frames_drop, exp_ok, exp_drop);
    end
  endtask

  task automatic test_mac_filter();
    set_frame(48'haabbccddeeff, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd1324, TS, -1);
    run_frame(-1, 1'b0);
    checks++;
    if (mon_data.size() != exp_n) begin failures++; $display("FAIL mac_count: got %0d required %0d", mon_data.size(), exp_n); end
    checks++;
    if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
      failures++; $display("FAIL mac_counters: ok=%0d drop=%0d required %0d %0d", frames_ok, frames_drop, exp_ok, exp_drop);
    end
  endtask

  task automatic test_proto_len();
    int total;
    set_frame(mac_local, 16'h0800, 8'h45, 8'h06, ip_local, port_local, 16'd1324, TS, -1);
    run_frame(-1, 1'b0);
    total = mon_data.size();
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd200, TS, -1);
    run_frame(-1, 1'b0);
    total += mon_data.size();
    checks++;
    if (total != 0) begin failures++; $display("FAIL proto_len_count: got %0d required 0", total); end
    checks++;
    if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
      failures++; $display("FAIL proto_len_counters: ok=%0d drop=%0d required %0d %0d", frames_ok, frames_drop, exp_ok, exp_drop);
    end
  endtask

  task automatic test_rx_error();
    int bad_data;
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd1324, TS, -1);
    run_frame(400, 1'b0);
    bad_data = 0;
    foreach (mon_data[i]) if (i < exp_n && mon_data[i] !== pay[i]) bad_data++;
    checks++;
    if (mon_data.size() != exp_n) begin failures++; $display("FAIL rxer_count: got %0d required %0d", mon_data.size(), exp_n); end
    checks++;
    if (bad_data != 0) begin failures++; $display("FAIL rxer_data: %0d bytes differ, required 0", bad_data); end
    checks++;
    if (mon_err != exp_err) begin failures++; $display("FAIL rxer_err: got %0d required %0d", mon_err, exp_err); end
    checks++;
    if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
      failures++; $display("FAIL rxer_counters: ok=%0d drop=%0d required %0d %0d", frames_ok, frames_drop, exp_ok, exp_drop);
    end
  endtask

  task automatic test_bad_sync();
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd1324, TS, 2);
    run_frame(-1, 1'b0);
    checks++;
    if (mon_data.size() != exp_n) begin failures++; $display("FAIL badsync_count: got %0d required %0d", mon_data.size(), exp_n); end
    checks++;
    if (mon_err_sync != exp_err_sync || mon_err != exp_err) begin
      failures++; $display("FAIL badsync_err: got %0d (%0d with sync) required %0d (%0d)", mon_err, mon_err_sync, exp_err, exp_err_sync);
    end
    checks++;
    if (frames_ok !== 16'(exp_ok)) begin failures++; $display("FAIL badsync_ok: got %0d required %0d", frames_ok, exp_ok); end
  endtask

  task automatic test_final_byte_err();
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd196, TS, -1);
    run_frame(187, 1'b1);
    checks++;
    if (mon_data.size() != exp_n) begin failures++; $display("FAIL lasterr_count: got %0d required %0d", mon_data.size(), exp_n); end
    checks++;
    if (mon_err != exp_err) begin failures++; $display("FAIL lasterr_err: got %0d required %0d", mon_err, exp_err); end
    checks++;
    if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
      failures++; $display("FAIL lasterr_counters: ok=%0d drop=%0d required %0d %0d", frames_ok, frames_drop, exp_ok, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      int n;
      n = $urandom_range(1, 7);
      set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'(n * TS + 8), TS, -1);
      run_frame(-1, 1'b0);
      checks++;
      if (mon_data.size() != exp_n) begin failures++; $display("FAIL b2b_count[%0d]: got %0d required %0d", f, mon_data.size(), exp_n); end
    end
    checks++;
    if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
      failures++; $display("FAIL b2b_counters: ok=%0d drop=%0d required %0d %0d", frames_ok, frames_drop, exp_ok, exp_drop);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int n, sel, er_at, bad_data;
      logic [47:0] mac; logic [31:0] ip; logic [15:0] port, etype, len;
      n = $urandom_range(1, 7); sel = $urandom_range(0, 5);
      mac = mac_local; ip = ip_local; port = port_local; etype = 16'h0800; len = 16'(n * TS + 8);
      er_at = -1;
      case (sel)
        1: mac[$urandom_range(0, 47)] ^= 1'b1;
        2: ip[$urandom_range(0, 31)] ^= 1'b1;
        3: port = port + 16'd1;
        4: len = len + 16'd1;
        5: etype = 16'h86DD;
        default: if ($urandom_range(0, 1) == 1) er_at = $urandom_range(1, n * TS - 1);
      endcase
      set_frame(mac, etype, 8'h45, 8'h11, ip, port, len, TS, -1);
      run_frame(er_at, 1'b0);
      bad_data = 0;
      foreach (mon_data[i]) if (i < exp_n && mon_data[i] !== pay[i]) bad_data++;
      checks++;
      if (mon_data.size() != exp_n || bad_data != 0) begin
        failures++; $display("FAIL rand_data[%0d]: got %0d bytes (%0d wrong) required %0d", f, mon_data.size(), bad_data, exp_n);
      end
      checks++;
      if (mon_err != exp_err) begin failures++; $display("FAIL rand_err[%0d]: got %0d required %0d", f, mon_err, exp_err); end
      checks++;
      if (frames_ok !== 16'(exp_ok) || frames_drop !== 16'(exp_drop)) begin
        failures++; $display("FAIL rand_counters[%0d]: ok=%0d drop=%0d required %0d %0d", f, frames_ok, frames_drop, exp_ok, exp_drop);
      end
    end
  endtask

  task automatic test_reset_mid_and_204();
    int n2, e2, es2, ok2, dr2, n1, e1, es1, ok1, dr1;
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd1324, TS, -1);
    clear_mon();
    send_frame(-1, 1'b0, 600);
    @(posedge clk); #2;
    rst_n = 1'b0; dv = 1'b0; er = 1'b0;
    #1;
    checks++;
    if (frames_ok !== 16'd0 || frames_drop !== 16'd0) begin
      failures++; $display("FAIL midrst_counters: ok=%0d drop=%0d required 0 0", frames_ok, frames_drop);
    end
    checks++;
    if ({ts_data, ts_valid, ts_sync, ts_err} !== 11'd0) begin
      failures++; $display("FAIL midrst_ts_outputs: got %h/%b/%b/%b required 0", ts_data, ts_valid, ts_sync, ts_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (24) @(posedge clk);
    set_frame(mac_local, 16'h0800, 8'h45, 8'h11, ip_local, port_local, 16'd1436, 204, -1);
    clear_mon();
    send_frame(-1, 1'b0, -1);
    model_frame(204, -1, n2, e2, es2, ok2, dr2);
    model_frame(TS, -1, n1, e1, es1, ok1, dr1);
    checks++;
    if (m2_n != n2 || m2_sync != (n2 + 203) / 204 || m2_bad != 0) begin
      failures++; $display("FAIL ts204_stream: got %0d bytes %0d syncs (%0d misplaced) required %0d %0d (0)",
                           m2_n, m2_sync, m2_bad, n2, (n2 + 203) / 204);
    end
    checks++;
    if (m2_err != e2) begin failures++; $display("FAIL ts204_err: got %0d required %0d", m2_err, e2); end
    checks++;
    if (frames2_ok !== 16'(ok2) || frames2_drop !== 16'(dr2)) begin
      failures++; $display("FAIL ts204_counters: ok=%0d drop=%0d required %0d %0d", frames2_ok, frames2_drop, ok2, dr2);
    end
    checks++;
    if (mon_data.size() != n1 || frames_ok !== 16'(ok1) || frames_drop !== 16'(dr1)) begin
      failures++; $display("FAIL ts188_after_reset: bytes=%0d ok=%0d drop=%0d required %0d %0d %0d",
                           mon_data.size(), frames_ok, frames_drop, n1, ok1, dr1);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_valid_frame();
    test_mac_filter();
    test_proto_len();
    test_rx_error();
    test_bad_sync();
    test_final_byte_err();
    test_back_to_back();
    test_random();
    test_reset_mid_and_204();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
